// File: rtl/traffic_light_pkg.sv
// Shared types for the four-way fixed-time traffic light controller:
// signal-head encoding, phase and direction enums, and round-robin order.
package traffic_light_pkg;

  localparam logic [1:0] LIGHT_RED    = 2'b00;
  localparam logic [1:0] LIGHT_YELLOW = 2'b01;
  localparam logic [1:0] LIGHT_GREEN  = 2'b10;

  // Encoding 2'b11 is unused and treated as a corrupted phase.
  typedef enum logic [1:0] {
    PH_GREEN  = 2'd0,
    PH_YELLOW = 2'd1,
    PH_ALLRED = 2'd2
  } phase_e;

  typedef enum logic [1:0] {
    DIR_N = 2'd0,
    DIR_E = 2'd1,
    DIR_S = 2'd2,
    DIR_W = 2'd3
  } dir_e;

  function automatic dir_e next_dir(input dir_e d);
    case (d)
      DIR_N:   next_dir = DIR_E;
      DIR_E:   next_dir = DIR_S;
      DIR_S:   next_dir = DIR_W;
      default: next_dir = DIR_N;
    endcase
  endfunction

  function automatic int cnt_width(input int max_dur);
    cnt_width = (max_dur > 1) ? $clog2(max_dur) : 1;
  endfunction

endpackage

// File: rtl/traffic_light_ctrl_phase_timer.sv
// Dwell counter: counts up from zero and flags done when it reaches the
// last cycle of the current phase; clears on done, reset or clr_i.
module phase_timer
  import traffic_light_pkg::*;
#(
  parameter int CNT_W = 1
) (
  input  logic             clk,
  input  logic             rst_i,
  input  logic             clr_i,
  input  logic [CNT_W-1:0] last_i,
  output logic             done_o
);

  logic [CNT_W-1:0] cnt_q;

  // >= rather than == so an out-of-range count cannot run past the phase end.
  assign done_o = (cnt_q >= last_i);

  always_ff @(posedge clk) begin
    if (rst_i || clr_i || done_o) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/traffic_light_ctrl.sv
// Fixed-time four-way controller: serves N, E, S, W in turn with
// green, yellow and all-red phases; lights decoded from registered state.
module traffic_light_ctrl
  import traffic_light_pkg::*;
#(
  parameter int GREEN_CYCLES  = 50,
  parameter int YELLOW_CYCLES = 10,
  parameter int ALLRED_CYCLES = 2
) (
  input  logic       clk,
  input  logic       reset,
  output logic [1:0] light_n,
  output logic [1:0] light_e,
  output logic [1:0] light_s,
  output logic [1:0] light_w
);

  localparam int MAX_DUR = (GREEN_CYCLES > YELLOW_CYCLES) ?
                           ((GREEN_CYCLES > ALLRED_CYCLES) ? GREEN_CYCLES : ALLRED_CYCLES) :
                           ((YELLOW_CYCLES > ALLRED_CYCLES) ? YELLOW_CYCLES : ALLRED_CYCLES);
  localparam int CNT_W = cnt_width(MAX_DUR);

  phase_e           phase_q;
  dir_e             dir_q;
  logic [CNT_W-1:0] timer_last;
  logic             timer_done;
  logic             phase_bad;
  logic [1:0]       lights [4];

  assign phase_bad = !(phase_q inside {PH_GREEN, PH_YELLOW, PH_ALLRED});

  always_comb begin
    timer_last = '0;
    case (phase_q)
      PH_GREEN:  timer_last = CNT_W'(GREEN_CYCLES - 1);
      PH_YELLOW: timer_last = CNT_W'(YELLOW_CYCLES - 1);
      PH_ALLRED: timer_last = CNT_W'(ALLRED_CYCLES - 1);
      default:   timer_last = '0;
    endcase
  end

  phase_timer #(
    .CNT_W (CNT_W)
  ) u_timer (
    .clk    (clk),
    .rst_i  (reset),
    .clr_i  (phase_bad),
    .last_i (timer_last),
    .done_o (timer_done)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      phase_q <= PH_GREEN;
      dir_q   <= DIR_N;
    end else begin
      case (phase_q)
        PH_GREEN:  if (timer_done) phase_q <= PH_YELLOW;
        PH_YELLOW: if (timer_done) phase_q <= PH_ALLRED;
        PH_ALLRED: if (timer_done) begin
          phase_q <= PH_GREEN;
          dir_q   <= next_dir(dir_q);
        end
        default: begin
          phase_q <= PH_GREEN;
          dir_q   <= DIR_N;
        end
      endcase
    end
  end

  // Only the served direction can be non-red; all-red leaves every head red.
  always_comb begin
    for (int i = 0; i < 4; i++) lights[i] = LIGHT_RED;
    case (phase_q)
      PH_GREEN:  lights[dir_q] = LIGHT_GREEN;
      PH_YELLOW: lights[dir_q] = LIGHT_YELLOW;
      default:   ;
    endcase
  end

  assign light_n = lights[DIR_N];
  assign light_e = lights[DIR_E];
  assign light_s = lights[DIR_S];
  assign light_w = lights[DIR_W];

endmodule

// File: tb/tb_traffic_light_ctrl.sv
// Bench for traffic_light_ctrl: three instances (default, short, minimum
// timings) driven by a shared reset and checked against a timeline model.
module tb_traffic_light_ctrl;

  localparam int NDUT = 3;
  localparam int G_P[NDUT] = '{50, 3, 1};
  localparam int Y_P[NDUT] = '{10, 1, 1};
  localparam int A_P[NDUT] = '{2, 1, 1};

  logic       clk;
  logic       reset;
  logic [1:0] ln [NDUT];
  logic [1:0] le [NDUT];
  logic [1:0] ls [NDUT];
  logic [1:0] lw [NDUT];

  // bit 24: entry follows a reset edge; [23:16] dut0, [15:8] dut1, [7:0] dut2
  logic [24:0] exp_q[$];

  int checks = 0;
  int errors = 0;
  int t_cyc  = 0;

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  traffic_light_ctrl #(.GREEN_CYCLES(50), .YELLOW_CYCLES(10), .ALLRED_CYCLES(2)) u_dut0 (
    .clk(clk), .reset(reset),
    .light_n(ln[0]), .light_e(le[0]), .light_s(ls[0]), .light_w(lw[0])
  );
  traffic_light_ctrl #(.GREEN_CYCLES(3), .YELLOW_CYCLES(1), .ALLRED_CYCLES(1)) u_dut1 (
    .clk(clk), .reset(reset),
    .light_n(ln[1]), .light_e(le[1]), .light_s(ls[1]), .light_w(lw[1])
  );
  traffic_light_ctrl #(.GREEN_CYCLES(1), .YELLOW_CYCLES(1), .ALLRED_CYCLES(1)) u_dut2 (
    .clk(clk), .reset(reset),
    .light_n(ln[2]), .light_e(le[2]), .light_s(ls[2]), .light_w(lw[2])
  );

  // ---------------- reference model ----------------
  // t = cycles since the last reset edge; returns {n,e,s,w}.
  function automatic logic [7:0] model(input int t, input int g, input int y, input int a);
    int slot, pos, d, r;
    logic [1:0] code;
    logic [7:0] res;
    slot = g + y + a;
    pos  = t % (4 * slot);
    d    = pos / slot;
    r    = pos % slot;
    if (r < g)          code = 2'b10;
    else if (r < g + y) code = 2'b01;
    else                code = 2'b00;
    res = 8'h00;
    res[7 - 2*d -: 2] = code;
    return res;
  endfunction

  // ---------------- driver ----------------
  task automatic step(input bit rst);
    logic [24:0] e;
    @(negedge clk);
    reset = rst;
    @(posedge clk);
    #1;
    if (rst) t_cyc = 0;
    else     t_cyc++;
    e[24] = rst;
    for (int k = 0; k < NDUT; k++)
      e[23 - 8*k -: 8] = model(t_cyc, G_P[k], Y_P[k], A_P[k]);
    exp_q.push_back(e);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step(1'b0);
  endtask

  // ---------------- scoreboard / monitor ----------------
  logic [7:0] prev_l [NDUT];
  bit         prev_ok = 1'b0;

  always @(negedge clk) begin
    logic [24:0] e;
    logic [7:0]  act, want;
    logic [1:0]  c, p;
    int          nonred;
    bit          bad;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      for (int k = 0; k < NDUT; k++) begin
        act  = {ln[k], le[k], ls[k], lw[k]};
        want = e[23 - 8*k -: 8];
        checks++;
        if (act !== want) begin
          errors++;
          $display("FAIL lights dut%0d t=%0d: got %b required %b", k, t_cyc, act, want);
        end
        nonred = 0;
        bad    = 1'b0;
        for (int d = 0; d < 4; d++) begin
          c = act[7 - 2*d -: 2];
          if (c === 2'b11 || $isunknown(c)) bad = 1'b1;
          if (c !== 2'b00) nonred++;
        end
        checks++;
        if (bad || nonred > 1) begin
          errors++;
          $display("FAIL exclusive dut%0d t=%0d: got %b required at most one non-red legal head", k, t_cyc, act);
        end
        if (prev_ok && !e[24]) begin
          bad = 1'b0;
          for (int d = 0; d < 4; d++) begin
            p = prev_l[k][7 - 2*d -: 2];
            c = act[7 - 2*d -: 2];
            if ((p == 2'b10 && c == 2'b00) || (p == 2'b00 && c == 2'b01) ||
                (p == 2'b01 && c == 2'b10)) bad = 1'b1;
          end
          checks++;
          if (bad) begin
            errors++;
            $display("FAIL sequence dut%0d t=%0d: got %b after %b required G->Y->R order", k, t_cyc, act, prev_l[k]);
          end
        end
        prev_l[k] = act;
      end
      prev_ok = 1'b1;
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    reset = 1'b1;
    step(1'b1);
    // Reach E yellow (t=115 at default timing) and reset there.
    run(114);
    step(1'b1);
    // Three full default rotations plus margin.
    run(3 * 248 + 20);
    for (int it = 0; it < 6; it++) begin
      int hold;
      hold = $urandom_range(1, 3);
      for (int h = 0; h < hold; h++) step(1'b1);
      run($urandom_range(10, 300));
    end
    @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending entries required 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
